// File: rtl/reg_ctx_pkg.sv
// Shared definitions for the register context engine.
// Holds the state encoding of the save/restore sequencer and the register
// heap geometry defaults, so the heap and the engine agree on sizes.
package reg_ctx_pkg;

  localparam int HEAP_DATA_W = 16;
  localparam int HEAP_ADDR_W = 4;
  localparam int HEAP_NREGS  = 2 ** HEAP_ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } ctx_state_t;

endpackage

// File: rtl/ctx_stack_mem.sv
// Context stack storage: DEPTH*NREGS words of DATA_W bits.
// Ports:
//   CLK    in   clock, rising edge
//   we     in   write enable (synchronous)
//   waddr  in   write address {context index, reg index}
//   wdata  in   write data
//   raddr  in   read address {context index, reg index}
//   rdata  out  read data, combinational from raddr
// No reset: stacked contents are don't-care until written by a save.
module ctx_stack_mem #(
  parameter int DATA_W = 16,
  parameter int AW     = 6,
  parameter int WORDS  = 64
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/reg_context_engine.sv
// Context save/restore sequencer for the register heap (interrupt entry/exit).
// Save walks every register through heap read port 1 and pushes the values
// onto a LIFO context stack; restore pops the newest context and writes it
// back through the heap write port.
// Ports:
//   CLK, RST (async, active-low)
//   save_i, restore_i        request pulses, honoured in IDLE only
//   busy_o, done_o, err_o    status; done_o/err_o are one-cycle pulses
//   full_o, empty_o, level_o stack occupancy
//   rdreg_o / rdata_i        heap read port 1 (rdata_i combinational)
//   regwrite_o, wrreg_o, wdata_o  heap write port (registered)
//
// state   | meaning
// IDLE    | waiting for a request, heap ports released
// SAVE    | rdreg_o = idx, capture rdata_i into stack slot `level`
// RESTORE | registered write of stack slot `level-1`, register idx
// DONE    | done_o pulse, level already updated
module reg_context_engine
  import reg_ctx_pkg::*;
#(
  parameter int DATA_W = HEAP_DATA_W,
  parameter int ADDR_W = HEAP_ADDR_W,
  parameter int NREGS  = HEAP_NREGS,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              save_i,
  input  logic              restore_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o,
  output logic [ADDR_W-1:0] rdreg_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              regwrite_o,
  output logic [ADDR_W-1:0] wrreg_o,
  output logic [DATA_W-1:0] wdata_o
);

  localparam int CTX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ctx_state_t        state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [LVL_W-1:0]  level;
  logic              full, empty;
  logic              last_idx;
  logic              req_save_ok, req_restore_ok, req_err;
  logic [CTX_W-1:0]  top_ctx;
  logic [ADDR_W-1:0] rd_idx;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign last_idx = (idx == ADDR_W'(NREGS - 1));
  assign top_ctx  = CTX_W'(level - LVL_W'(1));

  assign req_save_ok    = save_i && !restore_i && !full;
  assign req_restore_ok = restore_i && !save_i && !empty;
  // Any request that is not accepted (busy, conflicting, over/underflow) is
  // reported one cycle later.
  assign req_err = (state == IDLE) ?
                   ((save_i || restore_i) && !req_save_ok && !req_restore_ok) :
                   (save_i || restore_i);

  assign level_o = level;
  assign full_o  = full;
  assign empty_o = empty;

  ctx_stack_mem #(
    .DATA_W (DATA_W),
    .AW     (CTX_W + ADDR_W),
    .WORDS  (DEPTH * NREGS)
  ) u_stack (
    .CLK   (CLK),
    .we    (mem_we),
    .waddr ({level[CTX_W-1:0], idx}),
    .wdata (rdata_i),
    .raddr ({top_ctx, rd_idx}),
    .rdata (mem_rdata)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_save_ok) begin
          state_nxt = SAVE;
        end else if (req_restore_ok) begin
          state_nxt = RESTORE;
        end
      end
      SAVE:    if (last_idx) state_nxt = DONE;
      RESTORE: if (last_idx) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = 1'b0;
    done_o  = 1'b0;
    rdreg_o = '0;
    mem_we  = 1'b0;
    rd_idx  = '0;
    case (state)
      SAVE: begin
        busy_o  = 1'b1;
        rdreg_o = idx;
        mem_we  = 1'b1;
      end
      RESTORE: begin
        busy_o = 1'b1;
        // Fetch the word for the next registered write.
        rd_idx = idx + ADDR_W'(1);
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: idx/level counters and the registered heap write port.
  // During RESTORE, idx always equals wrreg_o (the write on the bus now).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idx        <= '0;
      level      <= '0;
      err_o      <= 1'b0;
      regwrite_o <= 1'b0;
      wrreg_o    <= '0;
      wdata_o    <= '0;
    end else begin
      err_o <= req_err;
      case (state)
        IDLE: begin
          idx <= '0;
          if (req_restore_ok) begin
            regwrite_o <= 1'b1;
            wrreg_o    <= '0;
            wdata_o    <= mem_rdata;
          end
        end
        SAVE: begin
          if (last_idx) begin
            idx   <= '0;
            level <= level + LVL_W'(1);
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        RESTORE: begin
          if (last_idx) begin
            idx        <= '0;
            level      <= level - LVL_W'(1);
            regwrite_o <= 1'b0;
            wrreg_o    <= '0;
            wdata_o    <= '0;
          end else begin
            idx     <= rd_idx;
            wrreg_o <= rd_idx;
            wdata_o <= mem_rdata;
          end
        end
        default: idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_context_engine.sv
module tb_reg_context_engine;

  logic        CLK;
  logic        RST;
  logic        save_i, restore_i;
  logic        busy_o, done_o, err_o, full_o, empty_o;
  logic [2:0]  level_o;
  logic [3:0]  rdreg_o;
  logic [15:0] rdata_i;
  logic        regwrite_o;
  logic [3:0]  wrreg_o;
  logic [15:0] wdata_o;

  reg_context_engine dut (
    .CLK        (CLK),
    .RST        (RST),
    .save_i     (save_i),
    .restore_i  (restore_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .level_o    (level_o),
    .rdreg_o    (rdreg_o),
    .rdata_i    (rdata_i),
    .regwrite_o (regwrite_o),
    .wrreg_o    (wrreg_o),
    .wdata_o    (wdata_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register heap model: combinational read, writes from the engine or a bulk fill.
  logic [15:0] heap [16];
  logic        fill_req;
  logic [15:0] fill_base, fill_inc;

  assign rdata_i = heap[rdreg_o];

  always @(posedge CLK) begin
    if (regwrite_o) begin
      heap[wrreg_o] <= wdata_o;
    end else if (fill_req) begin
      for (int k = 0; k < 16; k++) heap[k] <= fill_base + 16'(k) * fill_inc;
    end
  end

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  int  pending_err;
  int  checks;
  int  failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write, done or err.
  always @(negedge CLK) begin
    if (RST) begin
      if (err_o) begin
        if (pending_err > 0) begin
          check("err_pulse_expected", 32'(pending_err > 0), 32'd1);
          pending_err--;
        end else begin
          checks++; failures++;
          $display("FAIL unexpected_err: got err_o=1 expected none");
        end
      end
      if (regwrite_o) begin
        if (wr_q.size() > 0) begin
          wr_t e;
          e = wr_q.pop_front();
          check("wrreg", 32'(wrreg_o), 32'(e.a));
          check("wdata", 32'(wdata_o), 32'(e.d));
        end else begin
          checks++; failures++;
          $display("FAIL unexpected_write: got wrreg=%0h wdata=%0h expected none", wrreg_o, wdata_o);
        end
      end
      if (done_o) begin
        if (done_q.size() > 0) begin
          int lv;
          lv = done_q.pop_front();
          check("done_level", 32'(level_o), 32'(lv));
        end else begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done_o=1 level=%0d expected none", level_o);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic fill(input logic [15:0] base, input logic [15:0] inc);
    fill_base = base;
    fill_inc  = inc;
    fill_req  = 1'b1;
    @(negedge CLK);
    fill_req  = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic r);
    save_i    = s;
    restore_i = r;
    @(negedge CLK);
    save_i    = 1'b0;
    restore_i = 1'b0;
  endtask

  task automatic save_ctx(input int exp_level);
    done_q.push_back(exp_level);
    pulse(1'b1, 1'b0);
  endtask

  task automatic restore_ctx(input logic [15:0] base, input logic [15:0] inc, input int exp_level);
    wr_t e;
    for (int k = 0; k < 16; k++) begin
      e.a = 4'(k);
      e.d = base + 16'(k) * inc;
      wr_q.push_back(e);
    end
    done_q.push_back(exp_level);
    pulse(1'b0, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (busy_o) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got busy_o=1 after %0d cycles expected idle", name, n);
    end
  endtask

  initial begin
    checks = 0; failures = 0; pending_err = 0;
    save_i = 1'b0; restore_i = 1'b0;
    fill_req = 1'b0; fill_base = '0; fill_inc = '0;
    RST = 1'b0;
    tick(2);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_regwrite", 32'(regwrite_o), 0);
    check("rst_rdreg", 32'(rdreg_o), 0);
    check("rst_wrreg", 32'(wrreg_o), 0);
    check("rst_wdata", 32'(wdata_o), 0);
    check("rst_full", 32'(full_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_level", 32'(level_o), 0);
    RST = 1'b1;
    tick(1);

    // Round trip with latency and read sweep.
    fill(16'hA000, 16'h0001);
    save_ctx(1);
    for (int k = 0; k < 16; k++) begin
      check("save_rdreg_sweep", 32'(rdreg_o), 32'(k));
      tick(1);
    end
    check("save_latency_done", 32'(done_o), 1);
    check("save_level", 32'(level_o), 1);
    wait_idle("save1");
    fill(16'h0000, 16'h0000);
    restore_ctx(16'hA000, 16'h0001, 0);
    wait_idle("restore1");
    check("rt_level", 32'(level_o), 0);
    check("rt_empty", 32'(empty_o), 1);
    check("rt_heap5", 32'(heap[5]), 32'h0000A005);

    // Nested LIFO.
    fill(16'h1111, 16'h0000);
    save_ctx(1);
    wait_idle("save_a");
    fill(16'h2222, 16'h0000);
    save_ctx(2);
    wait_idle("save_b");
    restore_ctx(16'h2222, 16'h0000, 1);
    wait_idle("restore_b");
    restore_ctx(16'h1111, 16'h0000, 0);
    wait_idle("restore_a");

    // Overflow.
    for (int i = 0; i < 4; i++) begin
      fill(16'h3000 + 16'(i) * 16'h0100, 16'h0001);
      save_ctx(i + 1);
      wait_idle("save_fill");
    end
    check("full_after_4", 32'(full_o), 1);
    pending_err++;
    pulse(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("ovf_no_busy", 32'(busy_o), 0);
      check("ovf_no_sweep", 32'(rdreg_o), 0);
      tick(1);
    end
    check("ovf_level", 32'(level_o), 4);
    for (int i = 3; i >= 0; i--) begin
      restore_ctx(16'h3000 + 16'(i) * 16'h0100, 16'h0001, i);
      wait_idle("restore_drain");
    end

    // Underflow.
    pending_err++;
    pulse(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("unf_no_write", 32'(regwrite_o), 0);
      tick(1);
    end
    check("unf_level", 32'(level_o), 0);

    // Request while busy, and conflicting requests in IDLE.
    fill(16'h4400, 16'h0001);
    save_ctx(1);
    tick(4);
    pending_err++;
    pulse(1'b0, 1'b1);
    wait_idle("save_busy");
    check("busy_save_level", 32'(level_o), 1);
    pending_err++;
    pulse(1'b1, 1'b1);
    check("both_no_busy", 32'(busy_o), 0);
    tick(2);
    check("both_level", 32'(level_o), 1);

    // Reset in the middle of a restore.
    restore_ctx(16'h4400, 16'h0001, 0);
    tick(7);
    check("mid_wrreg7", 32'(wrreg_o), 7);
    #2;
    RST = 1'b0;
    #1;
    check("arst_regwrite", 32'(regwrite_o), 0);
    check("arst_busy", 32'(busy_o), 0);
    check("arst_level", 32'(level_o), 0);
    check("arst_empty", 32'(empty_o), 1);
    wr_q.delete();
    done_q.delete();
    @(negedge CLK);
    RST = 1'b1;
    tick(1);
    pending_err++;
    pulse(1'b0, 1'b1);
    tick(3);
    check("post_rst_no_write", 32'(regwrite_o), 0);

    check("err_all_seen", 32'(pending_err), 0);
    check("wr_q_drained", 32'(wr_q.size()), 0);
    check("done_q_drained", 32'(done_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
